// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack
// handshake and presents Instr / Opcode / Pc_plus4 in the IF/ID register.
// Branch and jump redirects from decode replace the PC; a misaligned
// redirect target parks the stage in S_FAULT until reset.
//
// Handshake: Imem_req is high only in S_REQ and, together with Imem_addr,
// is held stable from its first cycle until the cycle Imem_ack=1. The word
// on Imem_rdata is taken on that ack edge. Ack in any other state is ignored.
// Downstream consumes the IF/ID word on a cycle with Instr_valid=1 and
// Id_ready=1; a redirect on a valid word counts as consuming it.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        Imem_req,
   output logic [31:0] Imem_addr,
   input  logic [31:0] Imem_rdata,
   input  logic        Imem_ack,
   input  logic        Id_ready,
   input  logic        Branch_taken,
   input  logic [31:0] Branch_target,
   input  logic        Jump,
   input  logic [25:0] Jump_target,
   output logic [31:0] Instr,
   output logic [5:0]  Opcode,
   output logic [31:0] Pc_plus4,
   output logic        Instr_valid,
   output logic        Fetch_fault
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic        cons;
   logic        redir;
   logic [31:0] redir_target;
   logic        redir_misaligned;

   // Consumption and redirect decode; Jump wins over Branch_taken
   always_comb begin
      cons             = Instr_valid & Id_ready;
      redir            = Instr_valid & (Jump | Branch_taken);
      redir_target     = Jump ? {Pc_plus4[31:28], Jump_target, 2'b00} : Branch_target;
      redir_misaligned = (redir_target[1:0] != 2'b00);
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (redir && redir_misaligned)  state_nxt = S_FAULT;
            else if (redir)                 state_nxt = S_REQ;
            else if (!Instr_valid || cons)  state_nxt = S_REQ;
         end
         S_REQ:   if (Imem_ack) state_nxt = S_IDLE;
         S_FAULT: state_nxt = S_FAULT;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: request only while waiting for memory, address is the PC
   always_comb begin
      Imem_req  = (state == S_REQ);
      Imem_addr = pc;
      Opcode    = Instr[31:26];
   end

   // PC and IF/ID register updates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         Instr       <= 32'h0;
         Pc_plus4    <= 32'h0;
         Instr_valid <= 1'b0;
         Fetch_fault <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (redir && redir_misaligned) begin
                  Fetch_fault <= 1'b1;
                  Instr_valid <= 1'b0;
                  Instr       <= 32'h0;
               end else if (redir) begin
                  pc          <= redir_target;
                  Instr_valid <= 1'b0;
                  Instr       <= 32'h0;
               end else if (cons) begin
                  Instr_valid <= 1'b0;
               end
            end
            S_REQ: begin
               if (Imem_ack) begin
                  Instr       <= Imem_rdata;
                  Pc_plus4    <= pc + 32'd4;
                  pc          <= pc + 32'd4;
                  Instr_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle after the active edge.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        Imem_req;
   logic [31:0] Imem_addr;
   logic [31:0] Imem_rdata;
   logic        Imem_ack;
   logic        Id_ready;
   logic        Branch_taken;
   logic [31:0] Branch_target;
   logic        Jump;
   logic [25:0] Jump_target;
   logic [31:0] Instr;
   logic [5:0]  Opcode;
   logic [31:0] Pc_plus4;
   logic        Instr_valid;
   logic        Fetch_fault;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .Imem_req      (Imem_req),
      .Imem_addr     (Imem_addr),
      .Imem_rdata    (Imem_rdata),
      .Imem_ack      (Imem_ack),
      .Id_ready      (Id_ready),
      .Branch_taken  (Branch_taken),
      .Branch_target (Branch_target),
      .Jump          (Jump),
      .Jump_target   (Jump_target),
      .Instr         (Instr),
      .Opcode        (Opcode),
      .Pc_plus4      (Pc_plus4),
      .Instr_valid   (Instr_valid),
      .Fetch_fault   (Fetch_fault)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One active edge, then back to the sampling/driving point
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Serve one zero-wait fetch: request must be up at addr_exp, ack with data,
   // then the IF/ID register must show data and pcp4_exp.
   task automatic mem_cycle(input logic [31:0] addr_exp, input logic [31:0] data,
                            input logic [31:0] pcp4_exp);
      check_eq("req_up",    {31'd0, Imem_req}, 32'd1);
      check_eq("req_addr",  Imem_addr, addr_exp);
      Imem_rdata = data;
      Imem_ack   = 1'b1;
      tick();
      Imem_ack   = 1'b0;
      check_eq("valid_after_ack", {31'd0, Instr_valid}, 32'd1);
      check_eq("instr",     Instr, data);
      check_eq("pc_plus4",  Pc_plus4, pcp4_exp);
      check_eq("req_down",  {31'd0, Imem_req}, 32'd0);
   endtask

   task automatic redirect_branch(input logic [31:0] tgt);
      Branch_taken  = 1'b1;
      Branch_target = tgt;
      tick();
      Branch_taken  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; Imem_rdata = 32'h0; Imem_ack = 1'b0; Id_ready = 1'b0;
      Branch_taken = 1'b0; Branch_target = 32'h0; Jump = 1'b0; Jump_target = 26'h0;
      @(negedge clk);
      tick();

      // Reset state
      check_eq("rst_req",    {31'd0, Imem_req}, 32'd0);
      check_eq("rst_addr",   Imem_addr, 32'h0);
      check_eq("rst_instr",  Instr, 32'h0);
      check_eq("rst_opcode", {26'd0, Opcode}, 32'h0);
      check_eq("rst_pcp4",   Pc_plus4, 32'h0);
      check_eq("rst_valid",  {31'd0, Instr_valid}, 32'd0);
      check_eq("rst_fault",  {31'd0, Fetch_fault}, 32'd0);

      // First fetch after reset release, same-cycle ack
      rst = 1'b0;
      tick();
      mem_cycle(32'h0, 32'h8C01_0004, 32'h4);
      check_eq("lw_opcode", {26'd0, Opcode}, 32'h23);

      // Sequential stream at one instruction every two cycles
      Id_ready = 1'b1;
      tick();
      mem_cycle(32'h4, 32'h2001_0001, 32'h8);
      tick();
      mem_cycle(32'h8, 32'h2002_0002, 32'hC);
      tick();
      mem_cycle(32'hC, 32'h2003_0003, 32'h10);

      // Backpressure for 5 cycles; a stray ack must not disturb IF/ID
      Id_ready   = 1'b0;
      Imem_ack   = 1'b1;
      Imem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("bp_req",   {31'd0, Imem_req}, 32'd0);
         check_eq("bp_valid", {31'd0, Instr_valid}, 32'd1);
         check_eq("bp_instr", Instr, 32'h2003_0003);
         check_eq("bp_pcp4",  Pc_plus4, 32'h10);
      end
      Imem_ack = 1'b0;
      Id_ready = 1'b1;
      tick();
      mem_cycle(32'h10, 32'h0800_0010, 32'h14);
      check_eq("j_opcode", {26'd0, Opcode}, 32'h02);

      // Jump overrides a simultaneous branch
      Jump = 1'b1; Jump_target = 26'h10;
      Branch_taken = 1'b1; Branch_target = 32'h100;
      tick();
      Jump = 1'b0; Branch_taken = 1'b0;
      check_eq("jump_addr",  Imem_addr, 32'h40);
      check_eq("jump_req",   {31'd0, Imem_req}, 32'd1);
      check_eq("jump_valid", {31'd0, Instr_valid}, 32'd0);
      check_eq("jump_instr", Instr, 32'h0);
      mem_cycle(32'h40, 32'h1000_0003, 32'h44);

      // Branch, then ack delayed 3 cycles; redirects while invalid are ignored
      redirect_branch(32'h20);
      check_eq("br_addr",  Imem_addr, 32'h20);
      check_eq("br_valid", {31'd0, Instr_valid}, 32'd0);
      check_eq("br_instr", Instr, 32'h0);
      Jump = 1'b1; Jump_target = 26'h3FF;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("wait_req",   {31'd0, Imem_req}, 32'd1);
         check_eq("wait_addr",  Imem_addr, 32'h20);
         check_eq("wait_valid", {31'd0, Instr_valid}, 32'd0);
      end
      Jump = 1'b0;
      mem_cycle(32'h20, 32'h2004_0004, 32'h24);

      // PC wrap at the top of the address space
      redirect_branch(32'hFFFF_FFFC);
      mem_cycle(32'hFFFF_FFFC, 32'h2005_0005, 32'h0);
      tick();
      mem_cycle(32'h0, 32'h3C01_F000, 32'h4);

      // Jump keeps the upper PC+4 nibble
      redirect_branch(32'hF000_0000);
      mem_cycle(32'hF000_0000, 32'h0800_0010, 32'hF000_0004);
      Jump = 1'b1; Jump_target = 26'h10;
      tick();
      Jump = 1'b0;
      check_eq("jump_hi_addr", Imem_addr, 32'hF000_0040);
      mem_cycle(32'hF000_0040, 32'h2006_0006, 32'hF000_0044);

      // Misaligned branch faults; stage stays dead until reset
      redirect_branch(32'h22);
      check_eq("flt_fault", {31'd0, Fetch_fault}, 32'd1);
      check_eq("flt_valid", {31'd0, Instr_valid}, 32'd0);
      check_eq("flt_instr", Instr, 32'h0);
      Imem_ack = 1'b1; Jump = 1'b1; Jump_target = 26'h4; Branch_taken = 1'b1;
      Branch_target = 32'h40;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("flt_req",    {31'd0, Imem_req}, 32'd0);
         check_eq("flt_sticky", {31'd0, Fetch_fault}, 32'd1);
         check_eq("flt_novalid", {31'd0, Instr_valid}, 32'd0);
      end
      Imem_ack = 1'b0; Jump = 1'b0; Branch_taken = 1'b0;

      // Asynchronous reset clears the fault without a clock edge
      rst = 1'b1;
      #1;
      check_eq("arst_fault", {31'd0, Fetch_fault}, 32'd0);
      check_eq("arst_addr",  Imem_addr, 32'h0);
      check_eq("arst_req",   {31'd0, Imem_req}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      mem_cycle(32'h0, 32'h8C01_0004, 32'h4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the MIPS core; sits directly upstream of Control_unit and the decode stage. Holds the PC and fetches words from instruction memory over a req/ack handshake. Presents the fetched word, its Opcode field (Instr[31:26], feeding Control_unit.Opcode) and PC+4 in an IF/ID output register. Applies branch and jump redirects returned from decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
Imem_req  output  1  fetch request to instruction memory
Imem_addr  output  32  fetch byte address (= PC)
Imem_rdata  input  32  instruction word; valid when Imem_ack=1
Imem_ack  input  1  memory response strobe; one cycle per request
Id_ready  input  1  decode accepts current Instr this cycle
Branch_taken  input  1  redirect to Branch_target (from decode/Branch logic)
Branch_target  input  32  branch byte address
Jump  input  1  redirect to jump target (Control_unit.Jump)
Jump_target  input  26  Instr[25:0] of the jump instruction
Instr  output  32  IF/ID instruction register
Opcode  output  6  Instr[31:26], combinational from Instr
Pc_plus4  output  32  IF/ID PC+4 register
Instr_valid  output  1  Instr/Pc_plus4 hold an unconsumed instruction
Fetch_fault  output  1  sticky misaligned-redirect flag

Behaviour:
- Reset (async, rst=1): PC=RESET_PC, Instr=0 (Opcode 000000), Pc_plus4=0, Instr_valid=0, Fetch_fault=0, state=S_IDLE. Imem_req=0 while rst=1.
- FSM states: S_IDLE, S_REQ, S_FAULT.
- Imem_req=1 only in S_REQ; Imem_addr=PC at all times. Req and addr stay stable from first assertion until the ack cycle.
- Consume: cons = Instr_valid & Id_ready. Redirect: redir = Instr_valid & (Jump | Branch_taken); redir also counts as consumption.
- Redirect target: Jump has priority over Branch_taken.
  - Jump target = {Pc_plus4[31:28], Jump_target, 2'b00}.
  - Branch target = Branch_target.
  - Jump/Branch_taken are ignored when Instr_valid=0.
- S_IDLE:
  - If redir and target[1:0]!=0: Fetch_fault<=1, Instr_valid<=0, Instr<=0, state->S_FAULT.
  - Else if redir: PC<=target, Instr_valid<=0, Instr<=0, state->S_REQ.
  - Else if (!Instr_valid | cons): Instr_valid<=0 when cons, state->S_REQ.
  - Otherwise hold all registers.
- S_REQ:
  - Instr_valid is 0 throughout this state.
  - On Imem_ack: Instr<=Imem_rdata, Pc_plus4<=PC+4, PC<=PC+4, Instr_valid<=1, state->S_IDLE.
  - Without ack: hold, no timeout.
- Throughput: with zero-wait memory and Id_ready=1, one instruction every 2 cycles. Latency from req-with-ack to Instr_valid=1 is 1 cycle.
- S_FAULT: Imem_req=0, Instr_valid=0, all inputs ignored; leave only by reset.
- PC+4 arithmetic wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0); no flag.
- Imem_ack outside S_REQ is ignored.
- Reset mid-request: outstanding transaction is abandoned. After rst deasserts, the first Imem_req targets RESET_PC on the cycle after the first clock edge.
- When Instr_valid=0, Instr holds its last value (0 after reset or redirect). Downstream must qualify with Instr_valid.

Test Plan:
1. Reset: rst=1 then release; memory acks the same cycle with 32'h8C01_0004 → Imem_addr=0; Instr=8C01_0004, Opcode=100011, Pc_plus4=4, Instr_valid=1 one cycle after ack.
2. Sequential stream, Id_ready=1, zero-wait memory → Imem_addr sequence 0,4,8,C, with req asserted every other cycle. Pc_plus4 follows 4,8,C,10.
3. Backpressure: Id_ready=0 for 5 cycles with Instr valid → Imem_req=0, Instr and Pc_plus4 stable. Id_ready=1 → next req at PC+4 the following cycle.
4. Jump: Instr=0800_0010 (Opcode 000010), Jump=1, Jump_target=26'h10, Pc_plus4=8 → next Imem_addr=32'h0000_0040, Instr_valid=0, Instr=0. Branch_taken=1 same cycle with Branch_target=0x100 is overridden by the jump.
5. Branch: Branch_taken=1, Branch_target=32'h0000_0020 → next Imem_addr=0x20. Ack delayed 3 cycles: req and addr stable throughout.
6. Fault: Branch_taken=1, Branch_target=32'h0000_0022 → Fetch_fault=1, Imem_req=0 permanently. rst pulse → Fetch_fault=0, fetch resumes at RESET_PC.
